// File: rtl/uart_tx_arbiter.sv
// Frame-granular arbiter sharing one UART byte transmitter between response frames and FIFO-buffered NONCE frames.
// Optional build macro UART_TX_CRC_EN: NONCE trailer carries CRC-32 of bytes 0..7 instead of zeros.
module uart_tx_arbiter #(
  parameter int          NONCE_FIFO_DEPTH = 4,
  parameter logic [7:0]  NONCE_MSG_TYPE   = 8'h06
) (
  input  logic        comm_clk,
  input  logic        reset,
  input  logic        resp_valid,
  input  logic [7:0]  resp_data,
  input  logic        resp_last,
  output logic        resp_ready,
  input  logic        new_golden_ticket,
  input  logic [31:0] golden_nonce,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        nonce_overflow
);
  localparam int         PW       = (NONCE_FIFO_DEPTH > 1) ? $clog2(NONCE_FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(NONCE_FIFO_DEPTH);
  localparam logic [3:0] LAST_IDX = 4'd11;
  localparam logic       SRC_RESP  = 1'b0;
  localparam logic       SRC_NONCE = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic        src_r, grant_s, last_grant_r;
  logic [3:0]  idx_r;
  logic        last_r, cap_last_s, capture_s, pop_s, done_s;
  logic [7:0]  tx_byte_r, cap_byte_s, nonce_byte_s, trailer_s;
  logic        overflow_r, resp_ready_s, tx_start_s;
  logic [31:0] mem_r [NONCE_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PW:0] count_r;
  logic        fifo_empty_s, fifo_full_s, push_ok_s;
  logic [31:0] head_s;

  assign fifo_empty_s = (count_r == '0);
  assign fifo_full_s  = (count_r == FULL_CNT);
  assign head_s       = mem_r[rd_ptr_r];
  assign push_ok_s    = new_golden_ticket && (!fifo_full_s || pop_s);

`ifdef UART_TX_CRC_EN
  logic [31:0] crc_r, crc_final_s;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_final_s = crc_r ^ 32'hFFFFFFFF;

  // Trailer byte selection from the finished CRC, LSB first
  always_comb begin
    case (idx_r)
      4'd8:    trailer_s = crc_final_s[7:0];
      4'd9:    trailer_s = crc_final_s[15:8];
      4'd10:   trailer_s = crc_final_s[23:16];
      4'd11:   trailer_s = crc_final_s[31:24];
      default: trailer_s = 8'h00;
    endcase
  end

  // CRC restarts per frame and absorbs bytes 0..7 as they are loaded
  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      crc_r <= 32'hFFFFFFFF;
    end else if (state_r == GRANT) begin
      crc_r <= 32'hFFFFFFFF;
    end else if (capture_s && src_r == SRC_NONCE && idx_r < 4'd8) begin
      crc_r <= crc32_byte(crc_r, cap_byte_s);
    end
  end
`else
  assign trailer_s = 8'h00;
`endif

  // NONCE frame byte builder from the FIFO head
  always_comb begin
    case (idx_r)
      4'd0:    nonce_byte_s = 8'h0C;
      4'd1:    nonce_byte_s = 8'h00;
      4'd2:    nonce_byte_s = 8'h00;
      4'd3:    nonce_byte_s = NONCE_MSG_TYPE;
      4'd4:    nonce_byte_s = head_s[7:0];
      4'd5:    nonce_byte_s = head_s[15:8];
      4'd6:    nonce_byte_s = head_s[23:16];
      4'd7:    nonce_byte_s = head_s[31:24];
      default: nonce_byte_s = trailer_s;
    endcase
  end

  // Next-state, arbitration and handshake decode
  always_comb begin
    state_s      = state_r;
    grant_s      = src_r;
    resp_ready_s = 1'b0;
    capture_s    = 1'b0;
    cap_byte_s   = tx_byte_r;
    cap_last_s   = last_r;
    pop_s        = 1'b0;
    tx_start_s   = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (resp_valid && !fifo_empty_s) begin
          grant_s = ~last_grant_r;
          state_s = GRANT;
        end else if (resp_valid) begin
          grant_s = SRC_RESP;
          state_s = GRANT;
        end else if (!fifo_empty_s) begin
          grant_s = SRC_NONCE;
          state_s = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: state_s = LOAD;
      LOAD: begin
        if (src_r == SRC_RESP) begin
          resp_ready_s = resp_valid;
          if (resp_valid) begin
            capture_s  = 1'b1;
            cap_byte_s = resp_data;
            cap_last_s = resp_last;
            state_s    = START;
          end else begin
            state_s = LOAD;
          end
        end else begin
          capture_s  = 1'b1;
          cap_byte_s = nonce_byte_s;
          cap_last_s = (idx_r == LAST_IDX);
          state_s    = START;
        end
      end
      START: begin
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          state_s    = WAIT_BUSY;
        end else begin
          state_s = START;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_s = 1'b1;
          if (last_r) begin
            pop_s   = (src_r == SRC_NONCE);
            state_s = IDLE;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM, grant bookkeeping and held transmit byte
  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      src_r        <= SRC_NONCE;
      last_grant_r <= SRC_NONCE;
      idx_r        <= 4'd0;
      last_r       <= 1'b0;
      tx_byte_r    <= 8'h00;
    end else begin
      state_r <= state_s;
      src_r   <= grant_s;
      if (state_r == GRANT) begin
        last_grant_r <= src_r;
      end
      if (state_r == GRANT) begin
        idx_r <= 4'd0;
      end else if (done_s && src_r == SRC_NONCE) begin
        idx_r <= idx_r + 4'd1;
      end
      if (capture_s) begin
        tx_byte_r <= cap_byte_s;
        last_r    <= cap_last_s;
      end
    end
  end

  // Golden-nonce FIFO; a push while full only lands if the head pops the same cycle
  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NONCE_FIFO_DEPTH; i++) mem_r[i] <= 32'h00000000;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= new_golden_ticket && fifo_full_s && !pop_s;
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= golden_nonce;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign tx_byte        = tx_byte_r;
  assign tx_start       = tx_start_s;
  assign resp_ready     = resp_ready_s;
  assign nonce_overflow = overflow_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes queued at stimulus time, checked at each tx_start.
// Honours UART_TX_CRC_EN when computing the expected NONCE trailer.
module tb_uart_tx_arbiter;
  localparam int BUSY_CYC = 4;

  logic        comm_clk = 1'b0;
  logic        reset, resp_valid, resp_last, resp_ready;
  logic [7:0]  resp_data, tx_byte;
  logic        new_golden_ticket, tx_start, tx_busy, nonce_overflow;
  logic [31:0] golden_nonce;

  int checks = 0, errors = 0, start_cnt = 0, ovf_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] resp_bytes [0:15];

  always #5 comm_clk = ~comm_clk;

  uart_tx_arbiter dut (
    .comm_clk(comm_clk), .reset(reset),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .resp_ready(resp_ready),
    .new_golden_ticket(new_golden_ticket), .golden_nonce(golden_nonce),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy), .nonce_overflow(nonce_overflow)
  );

  // Transmitter model: busy from the cycle after the strobe for BUSY_CYC cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge comm_clk);
      if (tx_start === 1'b1 && reset === 1'b0) begin
        @(posedge comm_clk);
        #1 tx_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge comm_clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Output monitor: every strobe pops one expected byte
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge comm_clk);
      if (reset === 1'b0) begin
        if (tx_start === 1'b1) begin
          start_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx_start got %h want none", tx_byte);
          end else begin
            e = exp_q.pop_front();
            if (tx_byte !== e) begin
              errors++;
              $display("FAIL tx_byte got %h want %h", tx_byte, e);
            end
          end
        end
        if (nonce_overflow === 1'b1) ovf_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic logic [31:0] sw_crc(input logic [31:0] v);
    logic [7:0]  m [0:7];
    logic [31:0] c;
    m[0] = 8'h0C; m[1] = 8'h00; m[2] = 8'h00; m[3] = 8'h06;
    m[4] = v[7:0]; m[5] = v[15:8]; m[6] = v[23:16]; m[7] = v[31:24];
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) begin
      c = c ^ {24'h000000, m[k]};
      for (int b = 0; b < 8; b++) begin
        if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
        else      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic push_nonce_exp(input logic [31:0] v);
    logic [31:0] t;
`ifdef UART_TX_CRC_EN
    t = sw_crc(v);
`else
    t = 32'h00000000;
`endif
    exp_q.push_back(8'h0C); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h06);
    for (int k = 0; k < 4; k++) exp_q.push_back(v[8*k +: 8]);
    for (int k = 0; k < 4; k++) exp_q.push_back(t[8*k +: 8]);
  endtask

  task automatic pulse_nonce(input logic [31:0] v);
    new_golden_ticket = 1'b1;
    golden_nonce      = v;
    @(posedge comm_clk);
    #1 new_golden_ticket = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    resp_valid = 1'b1;
    resp_data  = d;
    resp_last  = l;
    while (!got && n < 3000) begin
      @(negedge comm_clk);
      if (resp_ready === 1'b1) got = 1'b1;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_handshake got timeout want resp_ready for %h", d);
    end
    @(posedge comm_clk);
    #1;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_byte(resp_bytes[i], (i == n - 1));
    resp_valid = 1'b0;
    resp_last  = 1'b0;
  endtask

  task automatic queue_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(resp_bytes[i]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge comm_clk);
      n++;
    end
    repeat (20) @(posedge comm_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got %0d pending want 0", name, exp_q.size());
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge comm_clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    resp_valid = 1'b0; resp_data = 8'h00; resp_last = 1'b0;
    new_golden_ticket = 1'b0; golden_nonce = 32'h00000000;
    repeat (3) @(posedge comm_clk);
    #1;
    checks += 4;
    if (tx_start !== 1'b0)       begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    if (tx_byte !== 8'h00)       begin errors++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
    if (resp_ready !== 1'b0)     begin errors++; $display("FAIL reset_resp_ready got %b want 0", resp_ready); end
    if (nonce_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", nonce_overflow); end
    @(posedge comm_clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_pong();
    int s0;
    s0 = start_cnt;
    exp_q.push_back(8'h01);
    resp_valid = 1'b1; resp_data = 8'h01; resp_last = 1'b1;
    @(negedge comm_clk);
    @(negedge comm_clk);
    checks++;
    if (resp_ready !== 1'b0) begin errors++; $display("FAIL pong_ready_c1 got %b want 0", resp_ready); end
    @(negedge comm_clk);
    checks++;
    if (resp_ready !== 1'b1) begin errors++; $display("FAIL pong_ready_c2 got %b want 1", resp_ready); end
    @(posedge comm_clk);
    #1 resp_valid = 1'b0; resp_last = 1'b0;
    @(negedge comm_clk);
    checks++;
    if (tx_start !== 1'b1 || tx_byte !== 8'h01) begin
      errors++;
      $display("FAIL pong_start_c3 got start=%b byte=%h want start=1 byte=01", tx_start, tx_byte);
    end
    @(posedge comm_clk);
    #1;
    wait_drain("pong");
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL pong_count got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_nonce();
    apply_reset();
    push_nonce_exp(32'h1FFFFFFF);
    pulse_nonce(32'h1FFFFFFF);
    wait_drain("nonce");
  endtask

  task automatic test_tie();
    apply_reset();
    for (int i = 0; i < 8; i++) resp_bytes[i] = 8'hA0 + 8'(i);
    queue_frame(8);
    push_nonce_exp(32'hCAFEBABE);
    fork
      pulse_nonce(32'hCAFEBABE);
      begin @(posedge comm_clk); #1; send_frame(8); end
    join
    wait_drain("tie1");
    resp_bytes[0] = 8'h01;
    queue_frame(1);
    send_frame(1);
    wait_drain("tie_pong");
    for (int i = 0; i < 8; i++) resp_bytes[i] = 8'hB0 + 8'(i);
    push_nonce_exp(32'h12345678);
    queue_frame(8);
    fork
      pulse_nonce(32'h12345678);
      begin @(posedge comm_clk); #1; send_frame(8); end
    join
    wait_drain("tie2");
  endtask

  task automatic test_overflow();
    int o0;
    apply_reset();
    o0 = ovf_cnt;
    for (int i = 0; i < 16; i++) resp_bytes[i] = 8'h40 + 8'(i);
    queue_frame(16);
    for (int k = 1; k <= 4; k++) push_nonce_exp(32'hD0000100 + 32'(k));
    fork
      send_frame(16);
      begin
        repeat (6) @(posedge comm_clk);
        #1;
        for (int k = 1; k <= 5; k++) pulse_nonce(32'hD0000100 + 32'(k));
      end
    join
    wait_drain("overflow");
    checks++;
    if (ovf_cnt - o0 != 1) begin errors++; $display("FAIL overflow_pulses got %0d want 1", ovf_cnt - o0); end
  endtask

  task automatic test_stall();
    int s;
    apply_reset();
    for (int i = 0; i < 4; i++) resp_bytes[i] = 8'h51 + 8'(i);
    queue_frame(4);
    push_nonce_exp(32'h0BADF00D);
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    resp_valid = 1'b0;
    pulse_nonce(32'h0BADF00D);
    repeat (20) @(posedge comm_clk);
    #1 s = start_cnt;
    repeat (50) @(posedge comm_clk);
    #1;
    checks++;
    if (start_cnt != s) begin errors++; $display("FAIL stall_no_start got %0d want 0", start_cnt - s); end
    resp_valid = 1'b1; resp_data = 8'h53; resp_last = 1'b0;
    @(negedge comm_clk);
    checks++;
    if (resp_ready !== 1'b1) begin errors++; $display("FAIL stall_resume_ready got %b want 1", resp_ready); end
    @(posedge comm_clk);
    #1;
    send_byte(8'h54, 1'b1);
    resp_valid = 1'b0; resp_last = 1'b0;
    wait_drain("stall");
  endtask

  task automatic test_reset_midframe();
    int s, n;
    apply_reset();
    push_nonce_exp(32'h55AA55AA);
    pulse_nonce(32'h55AA55AA);
    pulse_nonce(32'h66BB66BB);
    s = start_cnt;
    n = 0;
    while (start_cnt < s + 3 && n < 500) begin
      @(posedge comm_clk);
      n++;
    end
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge comm_clk);
    checks++;
    if (tx_start !== 1'b0 || tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs got start=%b byte=%h want start=0 byte=00", tx_start, tx_byte);
    end
    @(posedge comm_clk);
    #1 reset = 1'b0;
    s = start_cnt;
    repeat (40) @(posedge comm_clk);
    #1;
    checks++;
    if (start_cnt != s) begin errors++; $display("FAIL midreset_fifo_cleared got %0d starts want 0", start_cnt - s); end
  endtask

  task automatic test_crc();
    apply_reset();
    push_nonce_exp(32'h00000000);
    pulse_nonce(32'h00000000);
    wait_drain("crc");
  endtask

  initial begin
    test_reset();
    test_pong();
    test_nonce();
    test_tie();
    test_overflow();
    test_stall();
    test_reset_midframe();
    test_crc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-granular arbiter sharing the single UART byte transmitter between the command-response path (PONG, INFO, ACK, INVALID, RESEND) and golden-nonce reports from the hashing core. It buffers golden nonces in a small FIFO and builds the NONCE frame itself. The response path supplies complete pre-built frames as byte streams. Sits in the comm_clk domain between the command decoder, the nonce CDC output and the UART transmitter.

## Interface
- NONCE_FIFO_DEPTH, 4: golden-nonce FIFO entries; power of two, 2..16.
- NONCE_MSG_TYPE, 8'h06: message-type byte of the NONCE frame.

- comm_clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- resp_valid  in  1  response byte available.
- resp_data  in  8  response byte.
- resp_last  in  1  marks the final byte of a response frame.
- resp_ready  out  1  response byte consumed this cycle.
- new_golden_ticket  in  1  one-cycle pulse: golden_nonce is valid.
- golden_nonce  in  32  nonce found by the hashing core.
- tx_byte  out  8  byte handed to the UART transmitter.
- tx_start  out  1  one-cycle start strobe to the transmitter.
- tx_busy  in  1  transmitter shifting; rises the cycle after tx_start is accepted.
- nonce_overflow  out  1  one-cycle pulse: a nonce was dropped because the FIFO was full.

## Operation
- Reset values: tx_start=0, tx_byte=8'h00, resp_ready=0, nonce_overflow=0, FIFO empty, state IDLE, last_grant=NONCE. With last_grant=NONCE, the response source wins the first tie.
- Arbitration happens only in IDLE, at frame boundaries.
  - Candidates: resp_valid=1, and FIFO non-empty.
  - If both are present, the source not equal to last_grant wins (round-robin).
  - A granted frame is never interrupted.
- States:
  - IDLE → GRANT when any candidate is present.
  - GRANT → LOAD; last_grant updates here.
  - LOAD → START once a byte is held.
  - START → WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when tx_busy=1.
  - WAIT_DONE → LOAD when tx_busy=0 and the byte was not the last; → IDLE when the last byte is done.
- Response frame: in LOAD, resp_ready=resp_valid (combinational). The byte and resp_last are captured when both are high. If resp_valid=0, the block stalls in LOAD with the line idle. A single-byte frame (PONG 8'h01) is legal: resp_last is set on the first byte.
- NONCE frame: 12 bytes, built from the FIFO head.
  - Header: 8'h0C, 8'h00, 8'h00, NONCE_MSG_TYPE.
  - Nonce: 4 bytes, LSB first.
  - Trailer: 4 trailer bytes.
  - The FIFO head is popped in the WAIT_DONE cycle of byte 11.
  - A 4-bit byte index counts 0..11.
- FIFO:
  - Push on new_golden_ticket.
  - If the FIFO is full and no pop occurs in the same cycle, the new nonce is dropped and nonce_overflow pulses.
  - A simultaneous push and pop while full succeeds; occupancy stays full.
  - Pointers wrap modulo NONCE_FIFO_DEPTH.
- tx_start is asserted only in START, for exactly one cycle, and only when tx_busy=0. If tx_busy=1 on entering START, the strobe is held off until tx_busy=0.
- Reset mid-frame aborts the frame immediately. The FIFO is cleared and the line returns to IDLE. A partially consumed response frame is the responder's problem; the responder is reset by the same signal.

## Timing
- Latency, idle block with request at cycle 0:
  - GRANT at cycle 1.
  - LOAD at cycle 2.
  - For the response path, resp_ready=1 at cycle 2.
  - tx_start with a valid tx_byte at cycle 3.
- tx_byte is stable from START until the next LOAD capture.
- Back-to-back bytes within a frame: the next tx_start comes 2 cycles after tx_busy falls (WAIT_DONE→LOAD→START).
- Frame-to-frame gap: 4 cycles after the last tx_busy fall (IDLE, GRANT, LOAD, START).
- new_golden_ticket accepted every cycle; no back-pressure.

## Configuration
- UART_TX_CRC_EN defined:
  - The NONCE-frame trailer is CRC-32 over bytes 0..7, sent LSB first.
  - CRC parameters: reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - The CRC updates one byte per LOAD cycle.
- UART_TX_CRC_EN undefined: trailer bytes are 8'h00; no CRC logic is synthesized.
- Response frames pass through untouched in both builds.

## Test plan
- Single PONG: resp_data=8'h01, resp_last=1 → exactly one tx_start, tx_byte=8'h01 at cycle 3, return to IDLE.
- Nonce with CRC off: pulse golden_nonce=32'h1FFFFFFF → bytes 0C 00 00 06 FF FF FF 1F 00 00 00 00.
- Tie: 8-byte ACK frame and nonce arrive in the same cycle after reset → full ACK frame first, then the NONCE frame, with no interleaving. A second tie afterwards → NONCE first.
- Overflow: 5 nonce pulses while a 16-byte INFO frame is in flight (depth 4) → one nonce_overflow pulse; 4 NONCE frames follow, with the first 4 values in order.
- Stall: drop resp_valid for 50 cycles mid-frame → block holds in LOAD, no tx_start, no nonce frame inserted; resumes on the next valid.
- CRC on: nonce 32'h00000000 → trailer equals software CRC-32 of 0C 00 00 06 00 00 00 00, sent LSB first.
